fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage pipelined MIPS core, directly upstream of the decode stage.
//  Owns PC, issues requests to the Harvard instruction memory, applies jump/branch
//  redirects resolved in decode, and holds the IF/ID pipeline register (InstrD, PCPlus4D).
//  Tolerates a multi-cycle IMem (req/ready) and drops in-flight fetches on redirect.
// PARAMETERS
//  WIDTH          32      PC / instruction / address width
//  RESET_PC       32'h0   PC value after reset
//  NOP_INSTR      32'h0   instruction placed in IF/ID on a bubble (sll $0,$0,0)
//  PERF_CNT_WIDTH 32      width of the optional performance counters
// PORTS
//  CLK            in   1      clock, all state on rising edge
//  RST            in   1      synchronous, active-low reset
//  StallF         in   1      hazard unit: hold PC, ignore PCSrcD
//  StallD         in   1      hazard unit: hold IF/ID contents
//  PCSrcD         in   2      {jump, branch&equal} from decode
//  PCBranchD      in   WIDTH  branch target from decode
//  PCJumpD        in   WIDTH  jump target from decode
//  IMemAddr       out  WIDTH  instruction memory byte address (= PC while req)
//  IMemReq        out  1      fetch request
//  IMemRdata      in   WIDTH  instruction word, valid when IMemReady
//  IMemReady      in   1      request completes this cycle
//  InstrD         out  WIDTH  IF/ID instruction
//  PCPlus4D       out  WIDTH  IF/ID PC+4
//  ValidD         out  1      IF/ID holds a real instruction (0 = bubble)
//  FetchWaitF     out  1      1 while a request is outstanding and not ready
//  FetchCntF      out  PERF_CNT_WIDTH  instructions delivered to IF/ID (optional)
//  WaitCntF       out  PERF_CNT_WIDTH  cycles with FetchWaitF=1 (optional)
//  RedirCntF      out  PERF_CNT_WIDTH  redirects taken (optional)
// BEHAVIOUR
//  Reset (RST=0 at edge): PC=RESET_PC, state=IDLE, InstrD=NOP_INSTR, PCPlus4D=0,
//   ValidD=0, IMemReq=0, counters=0. Reset mid-request abandons it; late IMemReady ignored.
//  FSM: IDLE -> FETCH unconditionally (one dead cycle after reset).
//   FETCH: IMemReq=1, IMemAddr=PC. Redirect && !IMemReady -> DRAIN (target to PendPC).
//   DRAIN: IMemReq=1, IMemAddr=old PC held; on IMemReady discard data, PC=PendPC -> FETCH.
//   Further redirects in DRAIN overwrite PendPC (newest wins).
//  Redirect = !StallF && PCSrcD!=2'b00. Target: PCSrcD[1] ? PCJumpD : PCBranchD (jump wins on 2'b11).
//  PC update in FETCH: redirect -> target (same cycle as ready or not ready per above);
//   else IMemReady && !StallF -> PC+4 (mod 2^WIDTH, wraps silently); else hold.
//  IMemAddr/IMemReq stable while a request is outstanding (protocol rule).
//  IF/ID priority per edge: StallD -> hold all; redirect -> bubble (ValidD=0, InstrD=NOP_INSTR);
//   FETCH && IMemReady && !StallF -> InstrD=IMemRdata, PCPlus4D=PC+4, ValidD=1; else bubble.
//  StallF=1 with IMemReady=1: data not consumed, request repeats next cycle (same PC).
//  Latency: instruction reaches InstrD 1 edge after IMemReady; zero-wait IMem gives 1 instr/cycle.
//  PCSrcD ignored while StallF=1; hazard unit guarantees branch resolves with StallF=0.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: FetchCntF/WaitCntF/RedirCntF count as above, saturate at
//   all-ones, cleared by reset. Not defined: counter logic absent, the three ports tied to 0.
// STRUCTURE
//  mips_pkg: fetch state enum {IDLE,FETCH,DRAIN}, NOP_INSTR constant, PCSrc encodings
//   (PCSRC_SEQ=00, PCSRC_BR=01, PCSRC_JMP=1x).
//  Sub-module if_id_register: enable/clear pipeline register for {InstrD,PCPlus4D,ValidD}.
// TESTING
//  Zero-wait IMem, no hazards, RESET_PC=0 -> IMemAddr 0,4,8,...; InstrD follows 1 cycle later, ValidD=1.
//  IMemReady low 3 cycles at PC=0x8 -> IMemAddr held 0x8, FetchWaitF=1 x3, ValidD=0 x3, then instr@0x8.
//  PCSrcD=01, PCBranchD=0x40 with ready -> next IMemAddr=0x40, IF/ID bubble, ValidD=0 one cycle.
//  PCSrcD=11, PCJumpD=0x100, PCBranchD=0x40 -> PC=0x100 (jump priority).
//  Redirect to 0x80 while request at 0x10 not ready -> DRAIN; addr stays 0x10, data discarded, next 0x80.
//  StallF=StallD=1 for 2 cycles with PCSrcD=01 -> PC and InstrD unchanged; RST=0 mid-DRAIN -> PC=RESET_PC, IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: fetch FSM states,
// the bubble instruction word and the PC-source select encodings.
// Pure declarations, no logic or state.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // PC-source select from decode; bit 1 set means jump, regardless of bit 0
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // Jump takes priority over branch when both are flagged
  function automatic logic pcsrc_is_jump(input logic [1:0] pcsrc);
    return pcsrc[1];
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register holding {instr, pc_plus4, valid}.
// Latency: 1 cycle from load to outputs.
// Backpressure: hold freezes contents; otherwise load captures, else a bubble is inserted.
module if_id_register #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] instr_next,
  input  logic [WIDTH-1:0] pc_plus4_next,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             valid
);

  // Hold beats everything; without hold, either capture a fetched word or bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        instr    <= instr_next;
        pc_plus4 <= pc_plus4_next;
        valid    <= 1'b1;
      end else begin
        instr    <= NOP_INSTR;
        pc_plus4 <= '0;
        valid    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PC, drives a req/ready instruction memory, applies decode redirects.
// Latency: instruction appears in InstrD one edge after IMemReady; zero-wait IMem gives 1 instr/cycle.
// Backpressure: StallF holds PC and repeats the request, StallD freezes IF/ID; FETCH_PERF_CNT_EN adds perf counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                        WIDTH          = 32,
  parameter logic [WIDTH-1:0]          RESET_PC       = '0,
  parameter logic [WIDTH-1:0]          NOP_INSTR      = NOP_WORD,
  parameter int                        PERF_CNT_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      StallF,
  input  logic                      StallD,
  input  logic [1:0]                PCSrcD,
  input  logic [WIDTH-1:0]          PCBranchD,
  input  logic [WIDTH-1:0]          PCJumpD,
  output logic [WIDTH-1:0]          IMemAddr,
  output logic                      IMemReq,
  input  logic [WIDTH-1:0]          IMemRdata,
  input  logic                      IMemReady,
  output logic [WIDTH-1:0]          InstrD,
  output logic [WIDTH-1:0]          PCPlus4D,
  output logic                      ValidD,
  output logic                      FetchWaitF,
  output logic [PERF_CNT_WIDTH-1:0] FetchCntF,
  output logic [PERF_CNT_WIDTH-1:0] WaitCntF,
  output logic [PERF_CNT_WIDTH-1:0] RedirCntF
);

  fetch_state_t     state, state_next;
  logic [WIDTH-1:0] pc, pc_next;
  logic [WIDTH-1:0] pend_pc, pend_pc_next;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] target;
  logic             redir_req;
  logic             req;
  logic             take;

  assign redir_req = !StallF && (PCSrcD != PCSRC_SEQ);
  assign target    = pcsrc_is_jump(PCSrcD) ? PCJumpD : PCBranchD;
  assign pc_plus4  = pc + WIDTH'(4);

  // Next-state, PC selection and request generation
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    req          = 1'b0;
    take         = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (redir_req) begin
          if (IMemReady) begin
            pc_next = target;
          end else begin
            // Request in flight must finish at its original address first
            pend_pc_next = target;
            state_next   = DRAIN;
          end
        end else if (IMemReady && !StallF) begin
          pc_next = pc_plus4;
          take    = 1'b1;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (redir_req) begin
          pend_pc_next = target;
        end
        if (IMemReady) begin
          // Returned word belongs to the wrong path; drop it and resume at newest target
          pc_next    = redir_req ? target : pend_pc;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC and pending-redirect registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
    end
  end

  assign IMemReq    = req;
  assign IMemAddr   = pc;
  assign FetchWaitF = req && !IMemReady;

  if_id_register #(
    .WIDTH    (WIDTH),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk          (CLK),
    .rst_n        (RST),
    .hold         (StallD),
    .load         (take),
    .instr_next   (IMemRdata),
    .pc_plus4_next(pc_plus4),
    .instr        (InstrD),
    .pc_plus4     (PCPlus4D),
    .valid        (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] fetch_cnt, wait_cnt, redir_cnt;
  logic                      redir_taken;

  assign redir_taken = redir_req && (state != IDLE);

  // Saturating counters for delivered instructions, wait cycles and redirects
  always_ff @(posedge CLK) begin
    if (!RST) begin
      fetch_cnt <= '0;
      wait_cnt  <= '0;
      redir_cnt <= '0;
    end else begin
      if (take && !StallD && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + PERF_CNT_WIDTH'(1);
      if (FetchWaitF && (wait_cnt != '1))       wait_cnt  <= wait_cnt + PERF_CNT_WIDTH'(1);
      if (redir_taken && (redir_cnt != '1))     redir_cnt <= redir_cnt + PERF_CNT_WIDTH'(1);
    end
  end

  assign FetchCntF = fetch_cnt;
  assign WaitCntF  = wait_cnt;
  assign RedirCntF = redir_cnt;
`else
  assign FetchCntF = '0;
  assign WaitCntF  = '0;
  assign RedirCntF = '0;
`endif

endmodule
